// File: rtl/scan_scaler_pkg.sv
// Shared types and helpers for the integer pixel-replicating scan scaler.
// Scale factors are carried as "factor minus one" throughout.
package scan_scaler_pkg;

  localparam int unsigned MAX_SCALE_DEF = 4;
  localparam int unsigned SCALE_W       = 3;

  typedef logic [SCALE_W-1:0] scale_t;

  // Limit a requested factor-minus-one to the largest supported factor.
  function automatic scale_t clamp_scale(input scale_t s, input int unsigned max_scale);
    if (32'(s) + 32'd1 > max_scale) begin
      return SCALE_W'(max_scale - 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/scan_line_buffer.sv
// One-line pixel store: one write port, asynchronous read port.
// Holds the fetched source line so later lines can replay it.
module scan_line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/scan_scaler.sv
// Integer upscaler: replicates each framebuffer pixel SX times across a line
// and replays each fetched line SY times from a line buffer.
module scan_scaler
  import scan_scaler_pkg::*;
#(
  parameter int unsigned VGA_WIDTH = 640,
  parameter int unsigned PIXEL_W   = 16,
  parameter int unsigned MAX_SCALE = MAX_SCALE_DEF
) (
  input  logic                                               clk,
  input  logic                                               reset_i,
  input  logic                                               vga_vsync_i,
  input  logic                                               vga_de_i,
  input  logic [((MAX_SCALE > 1) ? $clog2(MAX_SCALE) : 1)-1:0] scale_x_i,
  input  logic [((MAX_SCALE > 1) ? $clog2(MAX_SCALE) : 1)-1:0] scale_y_i,
  input  logic [PIXEL_W-1:0]                                 fb_stream_data_i,
  output logic                                               fb_stream_ena_o,
  output logic [PIXEL_W-1:0]                                 stream_data_o
);

  localparam int unsigned COL_W = $clog2(VGA_WIDTH);

  logic [COL_W-1:0]   col_q, col_d, src_col_q, src_col_d;
  scale_t             sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  scale_t             sx_q, sx_d, sy_q, sy_d;
  logic               ena_q, ena_d;
  logic [PIXEL_W-1:0] data_q, data_d, held_q, held_d;
  logic [PIXEL_W-1:0] lb_rdata;
  logic               lb_we_c;
  logic               fetch_c;

  // Next-state: counters, factor latch, output pixel selection.
  always_comb begin
    col_d    = col_q;
    src_col_d = src_col_q;
    sub_x_d  = sub_x_q;
    sub_y_d  = sub_y_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ena_d    = 1'b0;
    data_d   = data_q;
    held_d   = held_q;
    lb_we_c  = 1'b0;
    fetch_c  = (sub_y_q == '0);

    if (!vga_vsync_i) begin
      sx_d = clamp_scale(SCALE_W'(scale_x_i), MAX_SCALE);
      sy_d = clamp_scale(SCALE_W'(scale_y_i), MAX_SCALE);
    end

    if (!vga_de_i) begin
      col_d     = '0;
      sub_x_d   = '0;
      src_col_d = '0;
    end else begin
      if (col_q == COL_W'(VGA_WIDTH - 1)) begin
        col_d     = '0;
        sub_x_d   = '0;
        src_col_d = '0;
        sub_y_d   = (sub_y_q >= sy_q) ? '0 : sub_y_q + SCALE_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
        if (sub_x_q >= sx_q) begin
          sub_x_d   = '0;
          src_col_d = src_col_q + COL_W'(1);
        end else begin
          sub_x_d = sub_x_q + SCALE_W'(1);
        end
      end

      // Fetch lines consume one word per group; replay lines read the buffer.
      if (fetch_c) begin
        if (sub_x_q == '0) begin
          data_d  = fb_stream_data_i;
          held_d  = fb_stream_data_i;
          lb_we_c = 1'b1;
          ena_d   = 1'b1;
        end else begin
          data_d = held_q;
        end
      end else begin
        data_d = lb_rdata;
      end
    end

    if (!vga_vsync_i) begin
      sub_y_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      col_q     <= '0;
      src_col_q <= '0;
      sub_x_q   <= '0;
      sub_y_q   <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      ena_q     <= 1'b0;
      data_q    <= '0;
      held_q    <= '0;
    end else begin
      col_q     <= col_d;
      src_col_q <= src_col_d;
      sub_x_q   <= sub_x_d;
      sub_y_q   <= sub_y_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ena_q     <= ena_d;
      data_q    <= data_d;
      held_q    <= held_d;
    end
  end

  scan_line_buffer #(
    .DEPTH (VGA_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (lb_we_c),
    .waddr_i (src_col_q),
    .wdata_i (fb_stream_data_i),
    .raddr_i (src_col_q),
    .rdata_o (lb_rdata)
  );

  assign fb_stream_ena_o = ena_q;
  assign stream_data_o   = data_q;

endmodule
